aes_host_ctrl: RTL and testbench

AES_HOST_CTRL -- requirements
Module: aes_host_ctrl

---
 rtl/aes_host_pkg.sv | 24 ++
 rtl/aes_host_ctrl.sv | 170 +++++++++++++++++
 tb/tb_aes_host_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_host_pkg.sv
// Shared types and constants for the AES host-side controller.
// Holds the FSM state encoding and the load/readout word counts.
package aes_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        READ_REQ,
        READ,
        RESP
    } state_t;

    localparam int LOAD_CYCLES = 9;
    localparam int READ_WORDS  = 4;
    localparam int BLOCK_WORDS = 4;
    localparam int WORD_W      = 32;

    // LOAD cycles 0 and 1 both present P0; later cycles step through P1..K3.
    function automatic int load_word_index(input int load_cycle);
        return (load_cycle == 0) ? 0 : load_cycle - 1;
    endfunction

endpackage

// File: rtl/aes_host_ctrl.sv
// Host-side controller for a word-serial AES core: loads plaintext and key,
// waits for done with a timeout, reads back the ciphertext, holds the response.
module aes_host_ctrl
    import aes_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int READ_LAT       = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] ciphertext,
    output logic         timeout_err,
    output logic         busy,
    output logic         core_start_n,
    output logic [31:0]  core_dword_in,
    input  logic         core_done,
    output logic         core_start_read_n,
    input  logic [31:0]  core_dword_out
);

    localparam int WCNT_MAX = (LOAD_CYCLES > READ_LAT + READ_WORDS) ? LOAD_CYCLES
                                                                     : READ_LAT + READ_WORDS;
    localparam int WCNT_W   = $clog2(WCNT_MAX + 1);
    localparam int TCNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WCNT_W-1:0] LOAD_LAST = WCNT_W'(LOAD_CYCLES - 1);
    localparam logic [WCNT_W-1:0] READ_SKIP = WCNT_W'(READ_LAT - 1);
    localparam logic [WCNT_W-1:0] READ_LAST = WCNT_W'(READ_LAT - 1 + READ_WORDS - 1);
    localparam logic [TCNT_W-1:0] TMO_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [WCNT_W-1:0]   word_cnt_reg, word_cnt_next;
    logic [TCNT_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic [127:0]        pt_reg, pt_next;
    logic [127:0]        key_reg, key_next;
    logic [127:0]        ct_reg, ct_next;
    logic                tmo_err_reg, tmo_err_next;
    logic                resp_valid_reg, resp_valid_next;
    logic                start_n_reg, start_n_next;
    logic                start_read_n_reg, start_read_n_next;
    logic [WORD_W-1:0]   dword_in_reg, dword_in_next;

    logic [2*BLOCK_WORDS*WORD_W-1:0] load_block;
    logic [WORD_W-1:0]               load_words [2*BLOCK_WORDS];
    logic [2:0]                      load_sel;

    // Word 0 of each operand sits in its top 32 bits.
    assign load_block = {pt_next, key_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2 * BLOCK_WORDS; gi++) begin : g_load_words
            assign load_words[gi] = load_block[(2*BLOCK_WORDS-gi)*WORD_W-1 -: WORD_W];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        pt_next       = pt_reg;
        key_next      = key_reg;
        ct_next       = ct_reg;
        tmo_err_next  = tmo_err_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    pt_next       = plaintext;
                    key_next      = key;
                    word_cnt_next = '0;
                    tmo_err_next  = 1'b0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                if (word_cnt_reg == LOAD_LAST) begin
                    tmo_cnt_next = '0;
                    state_next   = WAIT_DONE;
                end else begin
                    word_cnt_next = word_cnt_reg + WCNT_W'(1);
                end
            end
            WAIT_DONE: begin
                // done takes priority even in the last timeout cycle
                if (core_done) begin
                    state_next = READ_REQ;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    tmo_err_next = 1'b1;
                    ct_next      = '0;
                    state_next   = RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TCNT_W'(1);
                end
            end
            READ_REQ: begin
                word_cnt_next = '0;
                state_next    = READ;
            end
            READ: begin
                // Shift in so the first word read ends up in [127:96].
                if ((word_cnt_reg + WCNT_W'(1)) > READ_SKIP) begin
                    ct_next = {ct_reg[127-WORD_W:0], core_dword_out};
                end
                if (word_cnt_reg == READ_LAST) begin
                    state_next = RESP;
                end else begin
                    word_cnt_next = word_cnt_reg + WCNT_W'(1);
                end
            end
            RESP: begin
                if (resp_valid_reg && resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Registered outputs are derived from the upcoming state so they line up with it.
        load_sel          = 3'(load_word_index(int'(word_cnt_next)));
        start_n_next      = !((state_next == LOAD) && (word_cnt_next == '0));
        start_read_n_next = (state_next != READ_REQ);
        dword_in_next     = (state_next == LOAD) ? load_words[load_sel] : '0;
        resp_valid_next   = (state_next == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            word_cnt_reg     <= '0;
            tmo_cnt_reg      <= '0;
            pt_reg           <= '0;
            key_reg          <= '0;
            ct_reg           <= '0;
            tmo_err_reg      <= 1'b0;
            resp_valid_reg   <= 1'b0;
            start_n_reg      <= 1'b1;
            start_read_n_reg <= 1'b1;
            dword_in_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            word_cnt_reg     <= word_cnt_next;
            tmo_cnt_reg      <= tmo_cnt_next;
            pt_reg           <= pt_next;
            key_reg          <= key_next;
            ct_reg           <= ct_next;
            tmo_err_reg      <= tmo_err_next;
            resp_valid_reg   <= resp_valid_next;
            start_n_reg      <= start_n_next;
            start_read_n_reg <= start_read_n_next;
            dword_in_reg     <= dword_in_next;
        end
    end

    assign req_ready         = (state_reg == IDLE);
    assign busy              = (state_reg != IDLE);
    assign resp_valid        = resp_valid_reg;
    assign ciphertext        = ct_reg;
    assign timeout_err       = tmo_err_reg;
    assign core_start_n      = start_n_reg;
    assign core_start_read_n = start_read_n_reg;
    assign core_dword_in     = dword_in_reg;

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Bench for aes_host_ctrl: a behavioural word-serial AES core model on the core
// side, directed and random host requests checked against a latency/result model.
`timescale 1ns/1ps
module tb_aes_host_ctrl;

    localparam int TMO   = 8;
    localparam int RL    = 1;
    localparam int LOADN = 9;

    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         resp_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         core_done = 1'b0;
    logic [31:0]  core_dword_out = '0;
    logic         req_ready, resp_valid, timeout_err, busy, core_start_n, core_start_read_n;
    logic [127:0] ciphertext;
    logic [31:0]  core_dword_in;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aes_host_ctrl #(.TIMEOUT_CYCLES(TMO), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .plaintext(plaintext), .key(key),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .ciphertext(ciphertext), .timeout_err(timeout_err), .busy(busy),
        .core_start_n(core_start_n), .core_dword_in(core_dword_in),
        .core_done(core_done), .core_start_read_n(core_start_read_n),
        .core_dword_out(core_dword_out)
    );

    // Known-answer vectors map to their real ciphertexts; anything else gets a toy mix.
    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == PT1 && k == KEY1) return CT1;
        if (p == PT2 && k == KEY2) return CT2;
        return p ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Expected cycles from the accept edge to the first resp_valid cycle.
    function automatic int exp_latency(input int delay);
        if (delay >= 0 && delay < TMO) return 1 + LOADN + (delay + 1) + 1 + (RL - 1) + 4;
        return 1 + LOADN + TMO;
    endfunction

    // ---------------- core model ----------------
    int           cfg_done_delay = 0;
    bit           cfg_done_in_load = 1'b0;
    int           ld_idx = -1;
    int           wait_cnt = -1;
    int           rd_cnt = -1;
    int           rd_strobes = 0;
    int           start_strobes = 0;
    logic [31:0]  ld_words [LOADN];
    logic [127:0] core_ct = '0;

    always @(negedge clk) begin
        core_done = 1'b0;
        core_dword_out = $urandom;
        if (reset) begin
            ld_idx = -1;
            wait_cnt = -1;
            rd_cnt = -1;
        end else begin
            if (core_start_n === 1'b0) begin
                ld_idx = 0;
                wait_cnt = -1;
                start_strobes++;
            end
            if (ld_idx >= 0 && ld_idx < LOADN) begin
                ld_words[ld_idx] = core_dword_in;
                ld_idx++;
                if (cfg_done_in_load && ld_idx == 5) core_done = 1'b1;
                if (ld_idx == LOADN) begin
                    core_ct = core_fn({ld_words[0], ld_words[2], ld_words[3], ld_words[4]},
                                      {ld_words[5], ld_words[6], ld_words[7], ld_words[8]});
                    wait_cnt = 0;
                end
            end else if (wait_cnt >= 0) begin
                if (cfg_done_delay >= 0 && wait_cnt == cfg_done_delay) begin
                    core_done = 1'b1;
                    wait_cnt = -1;
                end else begin
                    wait_cnt++;
                end
            end
            if (rd_cnt >= 0) begin
                rd_cnt++;
                if (rd_cnt >= RL && rd_cnt < RL + 4)
                    core_dword_out = core_ct[127 - 32*(rd_cnt - RL) -: 32];
                if (rd_cnt >= RL + 3) rd_cnt = -1;
            end
            if (core_start_read_n === 1'b0) begin
                rd_strobes++;
                rd_cnt = 0;
            end
        end
    end

    // ---------------- host-side stimulus ----------------
    // Leaves the bench #1 into the first cycle after the accept edge.
    task automatic start_req(input logic [127:0] p, input logic [127:0] k, output bit ok);
        int n = 0;
        plaintext = p;
        key = k;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (req_ready === 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // lat counts cycles after the accept edge, starting at 1.
    task automatic wait_resp(output int lat, output bit ok);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = (resp_valid === 1'b1);
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (core_start_n !== 1'b1) begin bad++; $display("FAIL reset_start_n got=%b exp=1", core_start_n); end
        total++; if (core_start_read_n !== 1'b1) begin bad++; $display("FAIL reset_start_read_n got=%b exp=1", core_start_read_n); end
        total++; if (core_dword_in !== 32'h0) begin bad++; $display("FAIL reset_dword_in got=%h exp=0", core_dword_in); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL reset_ciphertext got=%h exp=0", ciphertext); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_fips_vector();
        bit ok;
        int lat;
        int s0;
        logic [31:0] exp_w [LOADN];
        exp_w = '{PT1[127:96], PT1[127:96], PT1[95:64], PT1[63:32], PT1[31:0],
                  KEY1[127:96], KEY1[95:64], KEY1[63:32], KEY1[31:0]};
        cfg_done_delay = 2;
        cfg_done_in_load = 1'b0;
        s0 = start_strobes;
        start_req(PT1, KEY1, ok);
        total++; if (!ok) begin bad++; $display("FAIL fips_accept got=timeout exp=accepted"); end
        total++; if (core_start_n !== 1'b0) begin bad++; $display("FAIL fips_start_n got=%b exp=0", core_start_n); end
        wait_resp(lat, ok);
        total++; if (!ok || lat != exp_latency(2)) begin bad++; $display("FAIL fips_latency got=%0d exp=%0d", lat, exp_latency(2)); end
        for (int i = 0; i < LOADN; i++) begin
            total++; if (ld_words[i] !== exp_w[i]) begin bad++; $display("FAIL fips_load_word%0d got=%h exp=%h", i, ld_words[i], exp_w[i]); end
        end
        total++; if (start_strobes != s0 + 1) begin bad++; $display("FAIL fips_start_count got=%0d exp=%0d", start_strobes - s0, 1); end
        total++; if (ciphertext !== CT1) begin bad++; $display("FAIL fips_ciphertext got=%h exp=%h", ciphertext, CT1); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL fips_timeout_err got=%b exp=0", timeout_err); end
        total++; if (core_dword_in !== 32'h0) begin bad++; $display("FAIL fips_dword_idle got=%h exp=0", core_dword_in); end
        $display("txn fips pt=%h ct=%h err=%0b lat=%0d", PT1, ciphertext, timeout_err, lat);
        ack();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        cfg_done_delay = 1;
        start_req(PT2, KEY2, ok);
        wait_resp(lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_resp got=no_resp exp=resp_valid"); end
        for (int c = 0; c < 10; c++) begin
            total++; if (resp_valid !== 1'b1 || ciphertext !== CT2 || req_ready !== 1'b0)
                begin bad++; $display("FAIL bp_hold cyc=%0d got=v%b ct=%h rdy=%b exp=v1 ct=%h rdy=0", c, resp_valid, ciphertext, req_ready, CT2); end
            @(posedge clk); #1;
        end
        $display("txn backpressure pt=%h ct=%h err=%0b lat=%0d", PT2, ciphertext, timeout_err, lat);
        ack();
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%b rdy=%b exp=v0 rdy1", resp_valid, req_ready); end
    endtask

    task automatic test_timeout();
        bit ok;
        int lat;
        int r0;
        cfg_done_delay = -1;
        r0 = rd_strobes;
        start_req(PT1, KEY1, ok);
        wait_resp(lat, ok);
        total++; if (!ok || lat != exp_latency(-1)) begin bad++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, exp_latency(-1)); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL tmo_ciphertext got=%h exp=0", ciphertext); end
        total++; if (rd_strobes != r0) begin bad++; $display("FAIL tmo_read_strobe got=%0d exp=0", rd_strobes - r0); end
        $display("txn timeout ct=%h err=%0b lat=%0d", ciphertext, timeout_err, lat);
        ack();
        cfg_done_delay = TMO - 1;
        start_req(PT2, KEY2, ok);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
        wait_resp(lat, ok);
        total++; if (!ok || lat != exp_latency(TMO - 1) || ciphertext !== CT2 || timeout_err !== 1'b0)
            begin bad++; $display("FAIL tmo_last_cycle_done got=lat%0d ct=%h err=%b exp=lat%0d ct=%h err=0", lat, ciphertext, timeout_err, exp_latency(TMO - 1), CT2); end
        $display("txn late_done ct=%h err=%0b lat=%0d", ciphertext, timeout_err, lat);
        ack();
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        int lat;
        int r0;
        cfg_done_delay = 0;
        start_req(PT2, KEY2, ok);
        repeat (4) @(posedge clk);
        #1;
        total++; if (core_dword_in !== PT2[31:0]) begin bad++; $display("FAIL rml_cycle4_word got=%h exp=%h", core_dword_in, PT2[31:0]); end
        r0 = rd_strobes;
        reset = 1'b1;
        #1;
        total++; if (core_start_n !== 1'b1 || core_start_read_n !== 1'b1 || core_dword_in !== 32'h0 ||
                     resp_valid !== 1'b0 || ciphertext !== 128'h0 || timeout_err !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL rml_async got=sn%b srn%b w%h v%b ct%h e%b b%b exp=reset_values",
                                  core_start_n, core_start_read_n, core_dword_in, resp_valid, ciphertext, timeout_err, busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rml_req_ready got=%b exp=1", req_ready); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || rd_strobes != r0 || resp_valid !== 1'b0)
            begin bad++; $display("FAIL rml_no_resume got=b%b rd%0d v%b exp=b0 rd0 v0", busy, rd_strobes - r0, resp_valid); end
        cfg_done_delay = 3;
        start_req(PT1, KEY1, ok);
        total++; if (core_start_n !== 1'b0 || core_dword_in !== PT1[127:96])
            begin bad++; $display("FAIL rml_fresh_start got=sn%b w%h exp=sn0 w%h", core_start_n, core_dword_in, PT1[127:96]); end
        wait_resp(lat, ok);
        total++; if (!ok || ciphertext !== CT1 || lat != exp_latency(3))
            begin bad++; $display("FAIL rml_result got=ct%h lat%0d exp=ct%h lat%0d", ciphertext, lat, CT1, exp_latency(3)); end
        $display("txn after_reset ct=%h err=%0b lat=%0d", ciphertext, timeout_err, lat);
        ack();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        int n = 0;
        cfg_done_delay = 2;
        plaintext = PT1;
        key = KEY1;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        plaintext = PT2;
        key = KEY2;
        wait_resp(lat, ok);
        total++; if (!ok || ciphertext !== CT1) begin bad++; $display("FAIL b2b_first got=%h exp=%h", ciphertext, CT1); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_no_same_cycle got=%b exp=0", req_ready); end
        $display("txn b2b_first ct=%h err=%0b lat=%0d", ciphertext, timeout_err, lat);
        ack();
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=rdy%b v%b exp=rdy1 v0", req_ready, resp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (busy !== 1'b1 || core_start_n !== 1'b0 || core_dword_in !== PT2[127:96])
            begin bad++; $display("FAIL b2b_second_accept got=b%b sn%b w%h exp=b1 sn0 w%h", busy, core_start_n, core_dword_in, PT2[127:96]); end
        wait_resp(lat, ok);
        total++; if (!ok || ciphertext !== CT2 || timeout_err !== 1'b0 || lat != exp_latency(2))
            begin bad++; $display("FAIL b2b_second got=ct%h e%b lat%0d exp=ct%h e0 lat%0d", ciphertext, timeout_err, lat, CT2, exp_latency(2)); end
        $display("txn b2b_second ct=%h err=%0b lat=%0d", ciphertext, timeout_err, lat);
        ack();
    endtask

    task automatic test_done_during_load();
        bit ok;
        int lat;
        cfg_done_in_load = 1'b1;
        cfg_done_delay = 4;
        start_req(PT1, KEY1, ok);
        wait_resp(lat, ok);
        total++; if (!ok || ciphertext !== CT1 || timeout_err !== 1'b0 || lat != exp_latency(4))
            begin bad++; $display("FAIL ddl_result got=ct%h e%b lat%0d exp=ct%h e0 lat%0d", ciphertext, timeout_err, lat, CT1, exp_latency(4)); end
        $display("txn done_in_load ct=%h err=%0b lat=%0d", ciphertext, timeout_err, lat);
        ack();
        cfg_done_in_load = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        int d;
        int hold;
        logic [127:0] p, k, exp_ct;
        bit exp_err;
        for (int t = 0; t < 16; t++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            d = $urandom_range(0, TMO + 1);
            hold = $urandom_range(0, 3);
            cfg_done_delay = d;
            cfg_done_in_load = ($urandom_range(0, 1) == 1);
            exp_err = (d >= TMO);
            exp_ct = exp_err ? 128'h0 : core_fn(p, k);
            start_req(p, k, ok);
            wait_resp(lat, ok);
            total++; if (!ok || ciphertext !== exp_ct || timeout_err !== exp_err || lat != exp_latency(d))
                begin bad++; $display("FAIL rand%0d got=ct%h e%b lat%0d exp=ct%h e%b lat%0d", t, ciphertext, timeout_err, lat, exp_ct, exp_err, exp_latency(d)); end
            total++; if (core_ct !== core_fn(p, k)) begin bad++; $display("FAIL rand%0d_load got=%h exp=%h", t, core_ct, core_fn(p, k)); end
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                total++; if (resp_valid !== 1'b1 || ciphertext !== exp_ct)
                    begin bad++; $display("FAIL rand%0d_hold got=v%b ct%h exp=v1 ct%h", t, resp_valid, ciphertext, exp_ct); end
            end
            $display("txn rand%0d pt=%h key=%h delay=%0d ct=%h err=%0b lat=%0d", t, p, k, d, ciphertext, timeout_err, lat);
            ack();
        end
        cfg_done_in_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fips_vector();
        test_backpressure();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        test_done_during_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
